// File: rtl/alu_muldiv_seq_if.sv
// Bundle between the execute stage and the multiply/divide sequencer.
// Carries the launch request (start_i, op_i, rs1_i, rs2_i), the status and result
// (busy_o, done_o, result_o) and the borrowed-ALU channel (alu_req_o, alu_a_o, alu_b_o,
// alu_op_o, alu_result_i). Signal suffixes are from the sequencer's point of view.
//   master: core / execute stage side
//   slave:  sequencer side
interface alu_muldiv_seq_if;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;
    logic        alu_req_o;
    logic [31:0] alu_a_o;
    logic [31:0] alu_b_o;
    logic [3:0]  alu_op_o;
    logic [31:0] alu_result_i;

    modport master (
        output start_i, op_i, rs1_i, rs2_i, alu_result_i,
        input  busy_o, done_o, result_o, alu_req_o, alu_a_o, alu_b_o, alu_op_o
    );

    modport slave (
        input  start_i, op_i, rs1_i, rs2_i, alu_result_i,
        output busy_o, done_o, result_o, alu_req_o, alu_a_o, alu_b_o, alu_op_o
    );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned MUL (low word) / DIVU / REMU sequencer that borrows the core's
// 32-bit ALU, issuing one ADD, SUB or SLTU per cycle.
// Ports:
//   clk_i   clock, rising edge
//   rst_ni  asynchronous active-low reset
//   bus     alu_muldiv_seq_if.slave: launch request, busy/done/result, ALU channel
module alu_muldiv_seq #(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    alu_muldiv_seq_if.slave   bus
);
    // Encodings match the core's ALU.svh constants.
    localparam logic [3:0] AluAdd  = 4'h0;
    localparam logic [3:0] AluSub  = 4'h1;
    localparam logic [3:0] AluSltu = 4'h3;

    typedef enum logic [2:0] {StIdle, StMulAdd, StDivCmp, StDivSub, StDone} state_e;

    state_e            state_q, state_d;
    // acc/rem, mcand/div and mplier/quo share storage between the two algorithms.
    logic [XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [1:0]        op_q, op_d;
    logic [5:0]        count_q, count_d;
    logic [XLEN-1:0]   shifted;
    logic [XLEN-1:0]   sel_result;

    // DIVU reads the quotient; MUL, REMU and the reserved op all read acc/rem.
    // Short-circuit results are pre-loaded into these registers at start.
    assign sel_result = (op_q == 2'b01) ? mplier_q : acc_q;
    // Remainder shifted left with the next dividend bit brought in from the top of quo.
    assign shifted    = {acc_q[XLEN-2:0], mplier_q[XLEN-1]};

    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        mcand_d       = mcand_q;
        mplier_d      = mplier_q;
        result_d      = result_q;
        op_d          = op_q;
        count_d       = count_q;
        bus.busy_o    = (state_q != StIdle);
        bus.done_o    = 1'b0;
        bus.result_o  = result_q;
        bus.alu_req_o = 1'b0;
        bus.alu_a_o   = '0;
        bus.alu_b_o   = '0;
        bus.alu_op_o  = '0;

        unique case (state_q)
            StIdle: begin
                if (bus.start_i) begin
                    op_d    = bus.op_i;
                    count_d = '0;
                    acc_d   = '0;
                    unique case (bus.op_i)
                        2'b00: begin
                            mcand_d  = bus.rs1_i;
                            mplier_d = bus.rs2_i;
                            state_d  = StMulAdd;
                        end
                        2'b01, 2'b10: begin
                            if (bus.rs2_i != '0) begin
                                mcand_d  = bus.rs2_i;
                                mplier_d = bus.rs1_i;
                                state_d  = StDivCmp;
                            end else begin
                                // Divide by zero: quo = all ones, rem = dividend.
                                acc_d    = bus.rs1_i;
                                mplier_d = '1;
                                state_d  = StDone;
                            end
                        end
                        default: state_d = StDone;
                    endcase
                end
            end
            StMulAdd: begin
                bus.alu_req_o = 1'b1;
                bus.alu_a_o   = acc_q;
                bus.alu_b_o   = mcand_q;
                bus.alu_op_o  = AluAdd;
                if (mplier_q[0]) acc_d = bus.alu_result_i;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 6'd1;
                if (count_q == 6'd31) state_d = StDone;
            end
            StDivCmp: begin
                bus.alu_req_o = 1'b1;
                bus.alu_a_o   = shifted;
                bus.alu_b_o   = mcand_q;
                bus.alu_op_o  = AluSltu;
                acc_d    = shifted;
                mplier_d = {mplier_q[XLEN-2:0], ~bus.alu_result_i[0]};
                count_d  = count_q + 6'd1;
                if (!bus.alu_result_i[0]) begin
                    state_d = StDivSub;
                end else if (count_q == 6'd31) begin
                    state_d = StDone;
                end
            end
            StDivSub: begin
                bus.alu_req_o = 1'b1;
                bus.alu_a_o   = acc_q;
                bus.alu_b_o   = mcand_q;
                bus.alu_op_o  = AluSub;
                acc_d   = bus.alu_result_i;
                state_d = (count_q == 6'd32) ? StDone : StDivCmp;
            end
            StDone: begin
                bus.done_o   = 1'b1;
                bus.result_o = sel_result;
                result_d     = sel_result;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            result_q <= '0;
            op_q     <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            result_q <= result_d;
            op_q     <= op_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: tb/tb_alu_muldiv_seq.sv
module tb_alu_muldiv_seq;
    localparam logic [3:0] AluAdd  = 4'h0;
    localparam logic [3:0] AluSub  = 4'h1;
    localparam logic [3:0] AluSltu = 4'h3;

    logic clk_i;
    logic rst_ni;
    int   checks;
    int   errors;

    alu_muldiv_seq_if bus ();

    alu_muldiv_seq dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Behavioural model of the core ALU.
    always_comb begin
        bus.alu_result_i = '0;
        case (bus.alu_op_o)
            AluAdd:  bus.alu_result_i = bus.alu_a_o + bus.alu_b_o;
            AluSub:  bus.alu_result_i = bus.alu_a_o - bus.alu_b_o;
            AluSltu: bus.alu_result_i = {31'd0, (bus.alu_a_o < bus.alu_b_o)};
            default: bus.alu_result_i = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents a request for one cycle; returns #1 after the accepting edge T.
    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk_i);
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.rs1_i   = a;
        bus.rs2_i   = b;
        @(posedge clk_i);
        #1;
        bus.start_i = 1'b0;
    endtask

    // Samples on negedges; k=1 is cycle T+1. Returns at the negedge of the cycle after done.
    task automatic observe(input string tag, input logic [31:0] exp, input int exp_lat,
                           input int exp_req, input logic [31:0] hold_val);
        int done_at  = -1;
        int done_cnt = 0;
        int req_cnt  = 0;
        logic [31:0] res = '0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk_i);
            if (k == 1 && exp_lat > 1) chk({tag, "_hold"}, bus.result_o, hold_val);
            if (bus.done_o) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = k;
                    res     = bus.result_o;
                end
            end
            if (bus.alu_req_o) req_cnt++;
            if (done_at > 0 && k == done_at + 1) begin
                chk({tag, "_idle_busy"}, {31'd0, bus.busy_o}, 32'd0);
                break;
            end
        end
        chk({tag, "_latency"}, done_at, exp_lat);
        chk({tag, "_result"}, res, exp);
        chk({tag, "_done_cnt"}, done_cnt, 32'd1);
        chk({tag, "_req_cycles"}, req_cnt, exp_req);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, {31'd0, bus.busy_o}, 32'd0);
        chk({tag, "_done"}, {31'd0, bus.done_o}, 32'd0);
        chk({tag, "_req"}, {31'd0, bus.alu_req_o}, 32'd0);
        chk({tag, "_result"}, bus.result_o, 32'd0);
        chk({tag, "_alu_a"}, bus.alu_a_o, 32'd0);
        chk({tag, "_alu_b"}, bus.alu_b_o, 32'd0);
        chk({tag, "_alu_op"}, {28'd0, bus.alu_op_o}, 32'd0);
    endtask

    initial begin
        int dcount;
        checks      = 0;
        errors      = 0;
        rst_ni      = 1'b0;
        bus.start_i = 1'b0;
        bus.op_i    = 2'b00;
        bus.rs1_i   = '0;
        bus.rs2_i   = '0;

        repeat (2) @(negedge clk_i);
        chk_outputs_zero("reset");
        rst_ni = 1'b1;

        launch(2'b00, 32'd7, 32'd6);
        observe("mul_7x6", 32'd42, 33, 32, 32'd0);
        launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        observe("mul_ones", 32'd1, 33, 32, 32'd42);
        launch(2'b00, 32'h0001_0000, 32'h0001_0000);
        observe("mul_wrap", 32'd0, 33, 32, 32'd1);
        launch(2'b01, 32'd100, 32'd7);
        observe("divu_100_7", 32'd14, 36, 35, 32'd0);
        launch(2'b10, 32'd100, 32'd7);
        observe("remu_100_7", 32'd2, 36, 35, 32'd14);
        launch(2'b01, 32'd5, 32'd0);
        observe("divu_by0", 32'hFFFF_FFFF, 1, 0, 32'd0);
        launch(2'b10, 32'd5, 32'd0);
        observe("remu_by0", 32'd5, 1, 0, 32'd0);
        launch(2'b11, 32'd9, 32'd3);
        observe("reserved", 32'd0, 1, 0, 32'd0);

        // start_i held through a whole MUL, then retargeted in the first IDLE cycle.
        @(negedge clk_i);
        bus.start_i = 1'b1;
        bus.op_i    = 2'b00;
        bus.rs1_i   = 32'd3;
        bus.rs2_i   = 32'd5;
        @(posedge clk_i);
        #1;
        observe("mul_held", 32'd15, 33, 32, 32'd0);
        chk("held_idle_result", bus.result_o, 32'd15);
        bus.op_i  = 2'b01;
        bus.rs1_i = 32'd100;
        bus.rs2_i = 32'd7;
        @(posedge clk_i);
        #1;
        bus.start_i = 1'b0;
        observe("divu_after_held", 32'd14, 36, 35, 32'd15);

        // Reset in the middle of a divide.
        launch(2'b01, 32'd100, 32'd7);
        repeat (10) @(negedge clk_i);
        chk("mid_div_busy", {31'd0, bus.busy_o}, 32'd1);
        rst_ni = 1'b0;
        #1;
        chk_outputs_zero("async_rst");
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        dcount = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_i);
            if (bus.done_o) dcount++;
        end
        chk("post_rst_no_done", dcount, 32'd0);
        launch(2'b01, 32'hFFFF_FFFF, 32'd1);
        observe("divu_max", 32'hFFFF_FFFF, 65, 64, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
